// File: rtl/cp0_unit.sv
// MIPS coprocessor-0 register file: timer, interrupt masking, exception/ERET
// bookkeeping and pipeline redirect generation for the memory stage.
module cp0_unit #(
  parameter int          HW_INT_NUM   = 6,
  parameter int          TIMER_DIV    = 2,
  parameter logic [31:0] PRID_VALUE   = 32'h004C0102,
  parameter logic [31:0] CONFIG_VALUE = 32'h00008000,
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [4:0]            waddr_i,
  input  logic [4:0]            raddr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o,
  input  logic [HW_INT_NUM-1:0] hw_int_i,
  input  logic                  exc_valid_i,
  input  logic [4:0]            exc_code_i,
  input  logic [31:0]           exc_pc_i,
  input  logic                  exc_bd_i,
  input  logic [31:0]           exc_badvaddr_i,
  input  logic                  eret_i,
  output logic                  int_req_o,
  output logic                  flush_o,
  output logic [31:0]           flush_pc_o,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o
);
  localparam int DW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

  logic [DW-1:0]         r_div;
  logic [31:0]           r_count, r_compare, r_badvaddr, r_epc;
  logic [7:0]            r_im;
  logic                  r_exl, r_ie, r_bd, r_ti;
  logic [1:0]            r_ip_sw;
  logic [4:0]            r_exccode;
  logic [HW_INT_NUM-1:0] r_hw;

  logic        w_wr_count, w_wr_compare, w_wr_status, w_wr_cause, w_wr_epc;
  logic        w_div_wrap;
  logic [5:0]  w_ip_hw;
  logic [7:0]  w_ip;
  logic [31:0] w_exc_epc, w_status, w_cause;

  assign w_wr_count   = we_i && (waddr_i == 5'd9);
  assign w_wr_compare = we_i && (waddr_i == 5'd11);
  assign w_wr_status  = we_i && (waddr_i == 5'd12);
  assign w_wr_cause   = we_i && (waddr_i == 5'd13);
  assign w_wr_epc     = we_i && (waddr_i == 5'd14);
  assign w_div_wrap   = (r_div == DW'(TIMER_DIV - 1));
  assign w_exc_epc    = exc_bd_i ? (exc_pc_i - 32'd4) : exc_pc_i;

  // Timer interrupt shares IP7 with hardware line 5.
  always_comb begin
    w_ip_hw = '0;
    w_ip_hw[HW_INT_NUM-1:0] = r_hw;
    w_ip_hw[5] = w_ip_hw[5] | r_ti;
  end
  assign w_ip     = {w_ip_hw, r_ip_sw};
  assign w_status = {9'b0, 1'b1, 6'b0, r_im, 6'b0, r_exl, r_ie};
  assign w_cause  = {r_bd, r_ti, 14'b0, w_ip, 1'b0, r_exccode, 2'b0};

  assign status_o  = w_status;
  assign cause_o   = w_cause;
  assign epc_o     = r_epc;
  assign int_req_o = r_ie & ~r_exl & (|(r_im & w_ip));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div   <= '0;
      r_count <= '0;
    end else if (w_wr_count) begin
      r_div   <= '0;
      r_count <= wdata_i;
    end else if (w_div_wrap) begin
      r_div   <= '0;
      r_count <= r_count + 32'd1;
    end else begin
      r_div   <= r_div + DW'(1);
    end
  end

  // A Compare write always wins over a coincident match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_compare <= '0;
      r_ti      <= 1'b0;
    end else if (w_wr_compare) begin
      r_compare <= wdata_i;
      r_ti      <= 1'b0;
    end else if (r_count == r_compare) begin
      r_ti      <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_im  <= '0;
      r_ie  <= 1'b0;
      r_exl <= 1'b0;
    end else begin
      if (w_wr_status) begin
        r_im  <= wdata_i[15:8];
        r_ie  <= wdata_i[0];
        r_exl <= wdata_i[1];
      end
      if (exc_valid_i)  r_exl <= 1'b1;
      else if (eret_i)  r_exl <= 1'b0;
    end
  end

  // EPC/BD are frozen while EXL is set so a nested fault keeps the original return point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_epc      <= '0;
      r_bd       <= 1'b0;
      r_exccode  <= '0;
      r_badvaddr <= '0;
      r_ip_sw    <= '0;
      r_hw       <= '0;
    end else begin
      r_hw <= hw_int_i;
      if (w_wr_cause) r_ip_sw <= wdata_i[9:8];
      if (w_wr_epc)   r_epc   <= wdata_i;
      if (exc_valid_i) begin
        r_exccode <= exc_code_i;
        if (!r_exl) begin
          r_epc <= w_exc_epc;
          r_bd  <= exc_bd_i;
        end
        if (exc_code_i == 5'd4 || exc_code_i == 5'd5) r_badvaddr <= exc_badvaddr_i;
      end
    end
  end

  always_comb begin
    flush_o    = 1'b0;
    flush_pc_o = '0;
    if (exc_valid_i) begin
      flush_o    = 1'b1;
      flush_pc_o = EXC_VECTOR;
    end else if (eret_i) begin
      flush_o    = 1'b1;
      flush_pc_o = w_wr_epc ? wdata_i : r_epc;
    end
  end

  always_comb begin
    rdata_o = '0;
    if (!rst) begin
      case (raddr_i)
        5'd8:    rdata_o = r_badvaddr;
        5'd9:    rdata_o = r_count;
        5'd11:   rdata_o = r_compare;
        5'd12:   rdata_o = w_status;
        5'd13:   rdata_o = w_cause;
        5'd14:   rdata_o = r_epc;
        5'd15:   rdata_o = PRID_VALUE;
        5'd16:   rdata_o = CONFIG_VALUE;
        default: rdata_o = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: reset, timer, hw interrupts, exceptions, ERET and collisions.
module tb_cp0_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i, raddr_i, exc_code_i;
  logic [31:0] wdata_i, rdata_o, exc_pc_i, exc_badvaddr_i;
  logic [5:0]  hw_int_i;
  logic        exc_valid_i, exc_bd_i, eret_i;
  logic        int_req_o, flush_o;
  logic [31:0] flush_pc_o, status_o, cause_o, epc_o;

  int nvec = 0;
  int nerr = 0;

  cp0_unit dut (
    .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .raddr_i(raddr_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .hw_int_i(hw_int_i),
    .exc_valid_i(exc_valid_i), .exc_code_i(exc_code_i), .exc_pc_i(exc_pc_i),
    .exc_bd_i(exc_bd_i), .exc_badvaddr_i(exc_badvaddr_i), .eret_i(eret_i),
    .int_req_o(int_req_o), .flush_o(flush_o), .flush_pc_o(flush_pc_o),
    .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
    we_i = 1'b1; waddr_i = r; wdata_i = d;
    step();
    we_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; raddr_i = 5'd12;
    repeat (3) @(posedge clk); #1;
    nvec++; if (rdata_o !== 32'h0) begin nerr++; $display("FAIL rst_rdata got %h want %h", rdata_o, 32'h0); end
    nvec++; if (status_o !== 32'h00400000) begin nerr++; $display("FAIL rst_status got %h want %h", status_o, 32'h00400000); end
    nvec++; if (int_req_o !== 1'b0) begin nerr++; $display("FAIL rst_intreq got %b want 0", int_req_o); end
    rst = 1'b0; raddr_i = 5'd9; #1;
    nvec++; if (rdata_o !== 32'h0) begin nerr++; $display("FAIL rst_count got %h want 0", rdata_o); end
    nvec++; if (cause_o !== 32'h0) begin nerr++; $display("FAIL rst_cause got %h want 0", cause_o); end
    repeat (7) step();
    nvec++; if (rdata_o !== 32'd3) begin nerr++; $display("FAIL count_run got %0d want 3", rdata_o); end
    nvec++; if (cause_o[30] !== 1'b1) begin nerr++; $display("FAIL ti_after_rst got %b want 1", cause_o[30]); end
    #2 rst = 1'b1; #1;
    nvec++; if (cause_o !== 32'h0) begin nerr++; $display("FAIL midrst_cause got %h want 0", cause_o); end
    nvec++; if (rdata_o !== 32'h0) begin nerr++; $display("FAIL midrst_rdata got %h want 0", rdata_o); end
    rst = 1'b0; #1;
    nvec++; if (rdata_o !== 32'h0) begin nerr++; $display("FAIL midrst_count got %h want 0", rdata_o); end
  endtask

  task automatic test_timer();
    bit seen = 0;
    mtc0(5'd9, 32'd0);
    mtc0(5'd11, 32'd5);
    nvec++; if (cause_o[30] !== 1'b0) begin nerr++; $display("FAIL cmp_clr_ti got %b want 0", cause_o[30]); end
    mtc0(5'd12, 32'h00008001);
    nvec++; if (int_req_o !== 1'b0) begin nerr++; $display("FAIL timer_early got %b want 0", int_req_o); end
    raddr_i = 5'd9;
    for (int i = 0; i < 30 && !seen; i++) begin
      step();
      if (cause_o[30]) seen = 1;
    end
    nvec++; if (!seen) begin nerr++; $display("FAIL timer_timeout got 0 want 1"); end
    nvec++; if (rdata_o !== 32'd5) begin nerr++; $display("FAIL ti_count got %0d want 5", rdata_o); end
    nvec++; if (int_req_o !== 1'b1) begin nerr++; $display("FAIL timer_int got %b want 1", int_req_o); end
    nvec++; if (cause_o[15] !== 1'b1) begin nerr++; $display("FAIL ip7_ti got %b want 1", cause_o[15]); end
    mtc0(5'd11, 32'd100);
    nvec++; if (cause_o[30] !== 1'b0 || int_req_o !== 1'b0) begin nerr++; $display("FAIL timer_ack got ti=%b irq=%b want 0 0", cause_o[30], int_req_o); end
  endtask

  task automatic test_hw_int();
    mtc0(5'd12, 32'h00001001);
    hw_int_i = 6'b000100; #1;
    nvec++; if (int_req_o !== 1'b0) begin nerr++; $display("FAIL hw_latency got %b want 0", int_req_o); end
    step();
    nvec++; if (cause_o[12] !== 1'b1) begin nerr++; $display("FAIL hw_ip4 got %b want 1", cause_o[12]); end
    nvec++; if (int_req_o !== 1'b1) begin nerr++; $display("FAIL hw_int got %b want 1", int_req_o); end
    mtc0(5'd12, 32'h00001003);
    nvec++; if (int_req_o !== 1'b0) begin nerr++; $display("FAIL hw_exl_mask got %b want 0", int_req_o); end
    hw_int_i = 6'b0;
    mtc0(5'd12, 32'h0);
    nvec++; if (status_o !== 32'h00400000) begin nerr++; $display("FAIL status_wr got %h want %h", status_o, 32'h00400000); end
  endtask

  task automatic test_exc_bd();
    exc_valid_i = 1'b1; exc_code_i = 5'd4; exc_pc_i = 32'h80001004;
    exc_bd_i = 1'b1; exc_badvaddr_i = 32'h13; #1;
    nvec++; if (flush_o !== 1'b1 || flush_pc_o !== 32'hBFC00380) begin nerr++; $display("FAIL exc_flush got %b/%h want 1/bfc00380", flush_o, flush_pc_o); end
    step();
    exc_valid_i = 1'b0; exc_bd_i = 1'b0; raddr_i = 5'd8; #1;
    nvec++; if (epc_o !== 32'h80001000) begin nerr++; $display("FAIL exc_epc got %h want 80001000", epc_o); end
    nvec++; if (cause_o[31] !== 1'b1 || cause_o[6:2] !== 5'd4) begin nerr++; $display("FAIL exc_cause got %h want bd=1 code=4", cause_o); end
    nvec++; if (status_o[1] !== 1'b1) begin nerr++; $display("FAIL exc_exl got %b want 1", status_o[1]); end
    nvec++; if (rdata_o !== 32'h13) begin nerr++; $display("FAIL exc_badva got %h want 13", rdata_o); end
    nvec++; if (flush_o !== 1'b0 || flush_pc_o !== 32'h0) begin nerr++; $display("FAIL idle_flush got %b/%h want 0/0", flush_o, flush_pc_o); end
  endtask

  task automatic test_nested();
    exc_valid_i = 1'b1; exc_code_i = 5'd8; exc_pc_i = 32'h80002000;
    exc_bd_i = 1'b0; exc_badvaddr_i = 32'hFFFF;
    step();
    exc_valid_i = 1'b0; raddr_i = 5'd8; #1;
    nvec++; if (epc_o !== 32'h80001000) begin nerr++; $display("FAIL nest_epc got %h want 80001000", epc_o); end
    nvec++; if (cause_o[6:2] !== 5'd8 || cause_o[31] !== 1'b1) begin nerr++; $display("FAIL nest_cause got %h want bd=1 code=8", cause_o); end
    nvec++; if (rdata_o !== 32'h13) begin nerr++; $display("FAIL nest_badva got %h want 13", rdata_o); end
    eret_i = 1'b1; #1;
    nvec++; if (flush_o !== 1'b1 || flush_pc_o !== 32'h80001000) begin nerr++; $display("FAIL eret_pc got %b/%h want 1/80001000", flush_o, flush_pc_o); end
    step();
    eret_i = 1'b0; #1;
    nvec++; if (status_o[1] !== 1'b0) begin nerr++; $display("FAIL eret_exl got %b want 0", status_o[1]); end
  endtask

  task automatic test_collide();
    exc_valid_i = 1'b1; eret_i = 1'b1; exc_code_i = 5'd12; exc_pc_i = 32'h80003000; exc_bd_i = 1'b0; #1;
    nvec++; if (flush_pc_o !== 32'hBFC00380) begin nerr++; $display("FAIL coll_vec got %h want bfc00380", flush_pc_o); end
    step();
    exc_valid_i = 1'b0; eret_i = 1'b0; #1;
    nvec++; if (status_o[1] !== 1'b1 || epc_o !== 32'h80003000) begin nerr++; $display("FAIL coll_state got exl=%b epc=%h want 1 80003000", status_o[1], epc_o); end
    eret_i = 1'b1; #1;
    nvec++; if (flush_pc_o !== 32'h80003000) begin nerr++; $display("FAIL coll_eret got %h want 80003000", flush_pc_o); end
    step();
    eret_i = 1'b0;
    we_i = 1'b1; waddr_i = 5'd12; wdata_i = 32'h0000FF01;
    exc_valid_i = 1'b1; exc_code_i = 5'd10; exc_pc_i = 32'h80004000;
    step();
    we_i = 1'b0; exc_valid_i = 1'b0; #1;
    nvec++; if (status_o !== 32'h0040FF03) begin nerr++; $display("FAIL mtc0_exc_status got %h want 0040ff03", status_o); end
    nvec++; if (epc_o !== 32'h80004000 || cause_o[6:2] !== 5'd10) begin nerr++; $display("FAIL mtc0_exc_epc got %h code %0d want 80004000 10", epc_o, cause_o[6:2]); end
    eret_i = 1'b1; we_i = 1'b1; waddr_i = 5'd14; wdata_i = 32'h80005550; #1;
    nvec++; if (flush_pc_o !== 32'h80005550) begin nerr++; $display("FAIL eret_bypass got %h want 80005550", flush_pc_o); end
    step();
    eret_i = 1'b0; we_i = 1'b0;
    raddr_i = 5'd15; #1;
    nvec++; if (rdata_o !== 32'h004C0102) begin nerr++; $display("FAIL prid got %h want 004c0102", rdata_o); end
    raddr_i = 5'd16; #1;
    nvec++; if (rdata_o !== 32'h00008000) begin nerr++; $display("FAIL config got %h want 00008000", rdata_o); end
    raddr_i = 5'd3; #1;
    nvec++; if (rdata_o !== 32'h0) begin nerr++; $display("FAIL unmapped got %h want 0", rdata_o); end
  endtask

  initial begin
    rst = 1'b1; we_i = 1'b0; waddr_i = '0; raddr_i = '0; wdata_i = '0;
    hw_int_i = '0; exc_valid_i = 1'b0; exc_code_i = '0; exc_pc_i = '0;
    exc_bd_i = 1'b0; exc_badvaddr_i = '0; eret_i = 1'b0;
    test_reset();
    test_timer();
    test_hw_int();
    test_exc_bd();
    test_nested();
    test_collide();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
